// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision adder slice: word width and
// sequencer state encodings.
package cla_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Generate term of one 4-bit lookahead group.
   function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level
// lookahead across the groups.
module cla16
   import cla_pkg::*;
(
   input  logic [WORD_W-1:0] A,
   input  logic [WORD_W-1:0] B,
   input  logic              Cin,
   output logic [WORD_W-1:0] sum,
   output logic              Cout
);

   logic [WORD_W-1:0] p;
   logic [WORD_W-1:0] g;
   logic [WORD_W-1:0] c;
   logic [3:0]        gg;
   logic [3:0]        gp;
   logic [4:0]        gc;

   always_comb begin
      p  = A ^ B;
      g  = A & B;
      gg = '0;
      gp = '0;
      for (int k = 0; k < 4; k++) begin
         gg[k] = group_gen(g[4*k +: 4], p[4*k +: 4]);
         gp[k] = &p[4*k +: 4];
      end
   end

   // Group carries are resolved in parallel from Cin, never rippled.
   always_comb begin
      gc[0] = Cin;
      gc[1] = gg[0] | (gp[0] & Cin);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & Cin);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);
   end

   always_comb begin
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
   end

   assign sum  = p ^ c;
   assign Cout = gc[4];

endmodule

// File: rtl/cla16_mp_sequencer.sv
// Multi-precision add/subtract: one shared cla16 stepped across the operand
// words LSW first, with the inter-word carry held in carry_q.
module cla16_mp_sequencer
   import cla_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [16*WORDS-1:0]   a_in,
   input  logic [16*WORDS-1:0]   b_in,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [16*WORDS-1:0]   result,
   output logic                  cout,
   output logic                  overflow
);

   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. start_ready is high only in IDLE, res_valid only in DONE;
   // valid/ready seen in any other state is ignored.

   state_t state_q;
   state_t state_d;

   logic [WORDS-1:0][WORD_W-1:0] a_lat;
   logic [WORDS-1:0][WORD_W-1:0] b_lat;
   logic [WORDS-1:0][WORD_W-1:0] res_q;
   logic [IDX_W-1:0]             idx;
   logic                         carry_q;
   logic                         cout_q;
   logic                         ovf_q;

   logic [WORD_W-1:0] w_a;
   logic [WORD_W-1:0] w_b;
   logic [WORD_W-1:0] w_sum;
   logic              w_cout;
   logic              last;

   assign w_a  = a_lat[idx];
   assign w_b  = b_lat[idx];
   assign last = (idx == LAST_IDX);

   cla16 u_cla16 (
      .A    (w_a),
      .B    (w_b),
      .Cin  (carry_q),
      .sum  (w_sum),
      .Cout (w_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last) state_d = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1; the inversion is applied once at accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat   <= '0;
         b_lat   <= '0;
         res_q   <= '0;
         idx     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  a_lat   <= a_in;
                  b_lat   <= sub ? ~b_in : b_in;
                  carry_q <= sub ? 1'b1 : cin;
                  idx     <= '0;
               end
            end
            ST_RUN: begin
               res_q[idx] <= w_sum;
               carry_q    <= w_cout;
               idx        <= idx + IDX_W'(1);
               if (last) begin
                  cout_q <= w_cout;
                  ovf_q  <= (w_a[WORD_W-1] == w_b[WORD_W-1]) &&
                            (w_sum[WORD_W-1] != w_a[WORD_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = res_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
